// File: rtl/fetch_unit_pkg.sv
// Constants and types shared by the instruction-fetch stage and its buffer.
package fetch_unit_pkg;

  localparam int unsigned FETCH_DEPTH = 2;
  localparam logic [31:0] BUBBLE_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc,inst} queue between instruction memory and the IF/ID register.
// Flush empties it in one cycle; a push and a pop in the same cycle keep the count.
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);

  fetch_entry_t r_mem [FETCH_DEPTH];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = pop_i && (r_count != 2'd0);
  assign w_push = push_i && ((r_count != 2'(FETCH_DEPTH)) || w_pop);

  // NOTE: the payload array is deliberately not reset; r_count alone says which
  // entries are live, so clearing storage would add reset fan-out for nothing.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign head_o  = r_mem[r_rd_ptr];
  assign count_o = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues up to two outstanding memory requests, drops
// responses made stale by a redirect, and presents in-order {PC,inst} to IF/ID.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] PC_o,
  output logic        valid_o
);

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_resp_pc;
  logic [1:0]   r_inflight;
  logic [1:0]   r_discard;

  logic [1:0]   w_count;
  logic [2:0]   w_outstanding;
  logic [1:0]   w_inflight_next;
  logic [31:0]  w_target;
  logic         w_grant;
  logic         w_drop;
  logic         w_push;
  logic         w_pop;
  fetch_entry_t w_entry;
  fetch_entry_t w_head;

  // Masking keeps every target bit in use while forcing word alignment.
  assign w_target      = redirect_pc_i & ~32'h0000_0003;
  assign w_outstanding = {1'b0, r_inflight} + {1'b0, w_count};

  // Buffered plus in-flight words never exceed the buffer depth, so a returning
  // response always has a free slot.
  assign imem_req_o  = rst_i && !redirect_i && (w_outstanding < 3'(FETCH_DEPTH));
  assign imem_addr_o = r_fetch_pc;
  assign w_grant     = imem_req_o && imem_gnt_i;

  assign w_drop  = imem_rvalid_i && (redirect_i || (r_discard != 2'd0));
  assign w_push  = imem_rvalid_i && !w_drop;
  assign valid_o = (w_count != 2'd0);
  assign w_pop   = valid_o && !stall_i && !redirect_i;
  assign w_entry = '{pc: r_resp_pc, inst: imem_rdata_i};

  assign w_inflight_next = r_inflight + 2'(w_grant) - 2'(imem_rvalid_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= 2'd0;
      r_discard  <= 2'd0;
    end else if (redirect_i) begin
      // Everything still outstanding after this edge belongs to the old path.
      r_fetch_pc <= w_target;
      r_resp_pc  <= w_target;
      r_inflight <= w_inflight_next;
      r_discard  <= w_inflight_next;
    end else begin
      r_inflight <= w_inflight_next;
      if (w_grant) r_fetch_pc <= next_pc(r_fetch_pc);
      if (w_push)  r_resp_pc  <= next_pc(r_resp_pc);
      if (w_drop)  r_discard  <= r_discard - 2'd1;
    end
  end

  fetch_buffer u_buffer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .data_i  (w_entry),
    .head_o  (w_head),
    .count_o (w_count)
  );

  // NOTE: outputs get their bubble values first so every path assigns them and
  // no latch is inferred.
  always_comb begin
    inst_o = BUBBLE_INST;
    PC_o   = 32'h0000_0000;
    if (valid_o) begin
      inst_o = w_head.inst;
      PC_o   = w_head.pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with variable grant/latency,
// a stream-level scoreboard, a cycle table, directed corner cases, random traffic.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'h0;
  logic [31:0] inst_o;
  logic [31:0] PC_o;
  logic        valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int sb_pops  = 0;

  // Memory model controls: gnt mode 0 = always, 1 = random, 2 = never.
  int mem_gnt_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] q_addr[$];
  int          q_due[$];

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_o        (inst_o),
    .PC_o          (PC_o),
    .valid_o       (valid_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_i      = 1'b0;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    repeat (n) step();
    rst_i = 1'b1;
  endtask

  // Instruction memory: in-order responses, one per cycle, lat_min..lat_max after grant.
  initial begin : memory
    forever begin
      @(posedge clk);
      #2;
      case (mem_gnt_mode)
        0:       imem_gnt_i = 1'b1;
        1:       imem_gnt_i = ($urandom_range(3) != 0);
        default: imem_gnt_i = 1'b0;
      endcase
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = inst_of(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      @(negedge clk);
      if (!rst_i) begin
        q_addr.delete();
        q_due.delete();
      end else if (imem_req_o && imem_gnt_i) begin
        q_addr.push_back(imem_addr_o);
        q_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        check("mem_outstanding_le2", 32'(q_addr.size() <= 2), 32'd1);
      end
    end
  end

  // Stream-level reference: consumed PCs run consecutively from the last reset or
  // redirect target, each carrying the word memory holds at that address.
  initial begin : scoreboard
    logic [31:0] exp_next;
    logic [31:0] exp_fetch;
    bit          post_flush;
    exp_next   = RST_PC;
    exp_fetch  = RST_PC;
    post_flush = 1'b0;
    forever begin
      @(negedge clk);
      if (post_flush) begin
        check("sb_flush_valid", 32'(valid_o), 32'd0);
        check("sb_flush_pc", PC_o, 32'h0);
        check("sb_flush_inst", inst_o, 32'h0);
      end
      if (!rst_i) begin
        check("sb_req_in_reset", 32'(imem_req_o), 32'd0);
        exp_next   = RST_PC;
        exp_fetch  = RST_PC;
        post_flush = 1'b1;
      end else if (redirect_i) begin
        check("sb_req_in_redirect", 32'(imem_req_o), 32'd0);
        exp_next   = redirect_pc_i & ~32'h3;
        exp_fetch  = redirect_pc_i & ~32'h3;
        post_flush = 1'b1;
      end else begin
        post_flush = 1'b0;
        if (imem_req_o) check("sb_req_addr", imem_addr_o, exp_fetch);
        if (imem_req_o && imem_gnt_i) exp_fetch = exp_fetch + 32'd4;
        if (valid_o) begin
          check("sb_pc", PC_o, exp_next);
          check("sb_inst", inst_o, inst_of(exp_next));
          if (!stall_i) begin
            exp_next = exp_next + 32'd4;
            sb_pops++;
          end
        end else begin
          check("sb_bubble_pc", PC_o, 32'h0);
          check("sb_bubble_inst", inst_o, 32'h0);
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    bit          stall;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
  } vec_t;

  initial begin : main
    vec_t        tbl[12];
    logic [31:0] held;
    int          n_rv;
    bit          seen_req;
    bit          found;
    int          pops0;

    // Zero-wait memory from reset, wrapping through 0; stalls on rows 8-9.
    tbl[0]  = '{1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8};
    tbl[3]  = '{1'b0, 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFFC};
    tbl[4]  = '{1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004};
    tbl[7]  = '{1'b0, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008};
    tbl[9]  = '{1'b1, 1'b0, 32'h0,         1'b1, 32'h0000_0008};
    tbl[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008};
    tbl[11] = '{1'b0, 1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C};

    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      stall_i = tbl[i].stall;
      @(negedge clk);
      check($sformatf("vec%0d_req", i), 32'(imem_req_o), 32'(tbl[i].req));
      if (tbl[i].req) check($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].addr);
      check($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].valid));
      check($sformatf("vec%0d_pc", i), PC_o, tbl[i].pc);
      check($sformatf("vec%0d_inst", i), inst_o, tbl[i].valid ? inst_of(tbl[i].pc) : 32'h0);
      step();
    end

    // Five-cycle stall: buffer fills to two, requests stop, head frozen.
    stall_i = 1'b1;
    held = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("stall%0d_req", i), 32'(imem_req_o), 32'd0);
        check($sformatf("stall%0d_valid", i), 32'(valid_o), 32'd1);
        if (i == 2) held = PC_o;
        else check($sformatf("stall%0d_pc", i), PC_o, held);
      end
      step();
    end
    check("stall_held_pc", held, 32'h0000_0010);
    stall_i = 1'b0;
    @(negedge clk);
    check("release0_valid", 32'(valid_o), 32'd1);
    check("release0_pc", PC_o, held);
    step();
    @(negedge clk);
    check("release1_valid", 32'(valid_o), 32'd1);
    check("release1_pc", PC_o, held + 32'd4);
    step();

    // Grant withheld for four cycles right after reset.
    mem_gnt_mode = 2;
    do_reset(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("nognt%0d_req", i), 32'(imem_req_o), 32'd1);
      check($sformatf("nognt%0d_addr", i), imem_addr_o, RST_PC);
      check($sformatf("nognt%0d_valid", i), 32'(valid_o), 32'd0);
      check($sformatf("nognt%0d_pc", i), PC_o, 32'h0);
      check($sformatf("nognt%0d_inst", i), inst_o, 32'h0);
      step();
    end
    mem_gnt_mode = 0;

    // Redirect to an unaligned target while two requests are outstanding.
    lat_min = 4;
    lat_max = 4;
    do_reset(1);
    step();
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk);
    check("redir_inflight", 32'(q_addr.size()), 32'd2);
    step();
    redirect_i = 1'b0;
    n_rv     = 0;
    seen_req = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_o) begin
        found = 1'b1;
        check("redir_first_pc", PC_o, 32'h0000_0100);
        check("redir_first_inst", inst_o, inst_of(32'h0000_0100));
        check("redir_rvalids_before_valid", 32'(n_rv), 32'd3);
      end else begin
        if (imem_rvalid_i) n_rv++;
        if (imem_req_o && !seen_req) begin
          seen_req = 1'b1;
          check("redir_first_req_addr", imem_addr_o, 32'h0000_0100);
        end
      end
      step();
    end
    check("redir_valid_within_budget", 32'(found), 32'd1);

    // One-cycle reset in the middle of a stream.
    lat_min = 1;
    lat_max = 1;
    repeat (6) step();
    rst_i = 1'b0;
    @(negedge clk);
    check("midrst_req", 32'(imem_req_o), 32'd0);
    step();
    rst_i = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_pc", PC_o, 32'h0);
    check("midrst_inst", inst_o, 32'h0);
    check("midrst_req_after", 32'(imem_req_o), 32'd1);
    check("midrst_addr_after", imem_addr_o, RST_PC);
    step();

    // Random traffic against the scoreboard.
    mem_gnt_mode = 1;
    lat_min = 1;
    lat_max = 3;
    pops0 = sb_pops;
    for (int i = 0; i < 3000; i++) begin
      stall_i       = ($urandom_range(99) < 30);
      redirect_i    = ($urandom_range(99) < 4);
      redirect_pc_i = $urandom;
      rst_i         = !($urandom_range(999) < 3);
      step();
    end
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    rst_i      = 1'b1;
    repeat (10) step();
    check("random_progress", 32'((sb_pops - pops0) > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
